// File: rtl/dp_exec_ctrl_pkg.sv
// Shared definitions for the data-processing execute controller: ALU control
// codes, ARM data-processing opcodes, condition-field encodings, controller
// state encoding and opcode classification helpers.
package dp_exec_ctrl_pkg;

    localparam int unsigned DataWidth   = 32;
    localparam int unsigned RegIdxWidth = 4;

    // ALU control codes shared with the combinational ALU
    localparam logic [4:0] AluAnd = 5'd0;
    localparam logic [4:0] AluEor = 5'd1;
    localparam logic [4:0] AluSub = 5'd2;
    localparam logic [4:0] AluRsb = 5'd3;
    localparam logic [4:0] AluAdd = 5'd4;
    localparam logic [4:0] AluAdc = 5'd5;
    localparam logic [4:0] AluSbc = 5'd6;
    localparam logic [4:0] AluRsc = 5'd7;
    localparam logic [4:0] AluOrr = 5'd8;
    localparam logic [4:0] AluMov = 5'd9;
    localparam logic [4:0] AluBic = 5'd10;
    localparam logic [4:0] AluMvn = 5'd11;
    localparam logic [4:0] AluPsa = 5'd12;

    // ARM data-processing opcodes
    localparam logic [3:0] OpAnd = 4'h0;
    localparam logic [3:0] OpEor = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpRsb = 4'h3;
    localparam logic [3:0] OpAdd = 4'h4;
    localparam logic [3:0] OpAdc = 4'h5;
    localparam logic [3:0] OpSbc = 4'h6;
    localparam logic [3:0] OpRsc = 4'h7;
    localparam logic [3:0] OpTst = 4'h8;
    localparam logic [3:0] OpTeq = 4'h9;
    localparam logic [3:0] OpCmp = 4'hA;
    localparam logic [3:0] OpCmn = 4'hB;
    localparam logic [3:0] OpOrr = 4'hC;
    localparam logic [3:0] OpMov = 4'hD;
    localparam logic [3:0] OpBic = 4'hE;
    localparam logic [3:0] OpMvn = 4'hF;

    // ARM condition field
    localparam logic [3:0] CondEq = 4'h0;
    localparam logic [3:0] CondNe = 4'h1;
    localparam logic [3:0] CondCs = 4'h2;
    localparam logic [3:0] CondCc = 4'h3;
    localparam logic [3:0] CondMi = 4'h4;
    localparam logic [3:0] CondPl = 4'h5;
    localparam logic [3:0] CondVs = 4'h6;
    localparam logic [3:0] CondVc = 4'h7;
    localparam logic [3:0] CondHi = 4'h8;
    localparam logic [3:0] CondLs = 4'h9;
    localparam logic [3:0] CondGe = 4'hA;
    localparam logic [3:0] CondLt = 4'hB;
    localparam logic [3:0] CondGt = 4'hC;
    localparam logic [3:0] CondLe = 4'hD;
    localparam logic [3:0] CondAl = 4'hE;
    localparam logic [3:0] CondNv = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWb   = 2'd2
    } state_e;

    function automatic logic [4:0] alu_code(input logic [3:0] op);
        logic [4:0] code;
        case (op)
            OpAnd, OpTst: code = AluAnd;
            OpEor, OpTeq: code = AluEor;
            OpSub, OpCmp: code = AluSub;
            OpAdd, OpCmn: code = AluAdd;
            OpRsb:        code = AluRsb;
            OpAdc:        code = AluAdc;
            OpSbc:        code = AluSbc;
            OpRsc:        code = AluRsc;
            OpOrr:        code = AluOrr;
            OpBic:        code = AluBic;
            OpMvn:        code = AluMvn;
            default:      code = AluMov;
        endcase
        return code;
    endfunction

    // TST/TEQ/CMP/CMN: flags only, never written back
    function automatic logic is_test(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // Arithmetic ops take C and V from the ALU; logical ops take C from the shifter
    function automatic logic is_arith(input logic [3:0] op);
        logic arith;
        case (op)
            OpSub, OpRsb, OpAdd, OpAdc, OpSbc, OpRsc, OpCmp, OpCmn: arith = 1'b1;
            default:                                                 arith = 1'b0;
        endcase
        return arith;
    endfunction

endpackage

// File: rtl/dp_exec_ctrl_if.sv
// Decode-to-execute handshake for one decoded data-processing instruction.
//   master: decode stage (drives instruction fields and in_valid)
//   slave : execute controller (drives in_ready)
interface dp_exec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_cond;
    logic        in_s;
    logic [3:0]  in_rd;
    logic [31:0] in_rn_data;
    logic [31:0] in_op2;
    logic        in_shift_c;

    modport master (
        output in_valid, in_opcode, in_cond, in_s, in_rd, in_rn_data, in_op2, in_shift_c,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_cond, in_s, in_rd, in_rn_data, in_op2, in_shift_c,
        output in_ready
    );
endinterface

// File: rtl/dp_exec_ctrl_cond_check.sv
// ARM condition-field evaluator (combinational).
//   cond  : condition field of the instruction
//   flags : CPSR NZCV, bit 3 = N
//   pass  : instruction should execute (NV never passes, AL always does)
module dp_exec_ctrl_cond_check
    import dp_exec_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            CondEq:  pass = z;
            CondNe:  pass = !z;
            CondCs:  pass = c;
            CondCc:  pass = !c;
            CondMi:  pass = n;
            CondPl:  pass = !n;
            CondVs:  pass = v;
            CondVc:  pass = !v;
            CondHi:  pass = c && !z;
            CondLs:  pass = !c || z;
            CondGe:  pass = n == v;
            CondLt:  pass = n != v;
            CondGt:  pass = !z && (n == v);
            CondLe:  pass = z || (n != v);
            CondAl:  pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/dp_exec_ctrl.sv
// Data-processing execute controller. Accepts one decoded instruction over a
// valid/ready handshake, checks its condition, drives registered ALU operands,
// then captures the ALU result for write-back and updates NZCV.
//   sysclk, nRESET : clock, asynchronous active-low reset
//   dec            : decode handshake (slave side)
//   alu_*          : registered ALU operands/control; alu_result/alu_signals back
//   wb_*           : one-cycle write-back strobe, register index and data
//   flags          : CPSR NZCV
//   cond_skip      : one-cycle pulse when an instruction fails its condition
// Build option: define COND_EXEC_EN to enable the condition check; otherwise
// every instruction executes as AL and cond_skip is held at 0.
module dp_exec_ctrl
    import dp_exec_ctrl_pkg::*;
(
    input  logic                 sysclk,
    input  logic                 nRESET,
    dp_exec_ctrl_if.slave        dec,
    output logic [DataWidth-1:0] alu_a,
    output logic [DataWidth-1:0] alu_b,
    output logic                 alu_c,
    output logic [4:0]           alu_cntrl,
    input  logic [DataWidth-1:0] alu_result,
    input  logic [3:0]           alu_signals,
    output logic                 wb_valid,
    output logic [RegIdxWidth-1:0] wb_rd,
    output logic [DataWidth-1:0] wb_data,
    output logic [3:0]           flags,
    output logic                 cond_skip
);
    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic                   alu_c_q, alu_c_d;
    logic [4:0]             alu_cntrl_q, alu_cntrl_d;
    logic [RegIdxWidth-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic                   shift_c_q, shift_c_d;
    logic                   wr_en_q, wr_en_d;
    logic                   set_flags_q, set_flags_d;
    logic                   arith_q, arith_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [DataWidth-1:0]   wb_data_q, wb_data_d;
    logic [3:0]             flags_q, flags_d;
    logic                   accept, cond_pass;

    assign dec.in_ready = (state_q == StIdle);
    assign accept       = dec.in_valid && dec.in_ready;

`ifdef COND_EXEC_EN
    logic cond_skip_q;

    dp_exec_ctrl_cond_check u_cond_check (
        .cond  (dec.in_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_ff @(posedge sysclk or negedge nRESET) begin
        if (!nRESET) cond_skip_q <= 1'b0;
        else         cond_skip_q <= accept && !cond_pass;
    end
    assign cond_skip = cond_skip_q;
`else
    logic [3:0] unused_cond;
    assign unused_cond = dec.in_cond;
    assign cond_pass   = 1'b1;
    assign cond_skip   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_c_d     = alu_c_q;
        alu_cntrl_d = alu_cntrl_q;
        rd_d        = rd_q;
        shift_c_d   = shift_c_q;
        wr_en_d     = wr_en_q;
        set_flags_d = set_flags_q;
        arith_d     = arith_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        flags_d     = flags_q;

        case (state_q)
            StIdle: begin
                if (accept && cond_pass) begin
                    alu_a_d     = dec.in_rn_data;
                    alu_b_d     = dec.in_op2;
                    alu_c_d     = flags_q[1];
                    alu_cntrl_d = alu_code(dec.in_opcode);
                    rd_d        = dec.in_rd;
                    shift_c_d   = dec.in_shift_c;
                    wr_en_d     = !is_test(dec.in_opcode);
                    set_flags_d = dec.in_s || is_test(dec.in_opcode);
                    arith_d     = is_arith(dec.in_opcode);
                    state_d     = StExec;
                end
            end
            StExec: begin
                wb_data_d  = alu_result;
                wb_rd_d    = rd_q;
                wb_valid_d = wr_en_q;
                if (set_flags_q) begin
                    // Logical ops keep V and take C from the shifter carry latched at accept
                    flags_d = arith_q ? alu_signals
                                      : {alu_signals[3:2], shift_c_q, flags_q[0]};
                end
                state_d = StWb;
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= StIdle;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_q     <= 1'b0;
            alu_cntrl_q <= AluPsa;
            rd_q        <= '0;
            shift_c_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            set_flags_q <= 1'b0;
            arith_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_c_q     <= alu_c_d;
            alu_cntrl_q <= alu_cntrl_d;
            rd_q        <= rd_d;
            shift_c_q   <= shift_c_d;
            wr_en_q     <= wr_en_d;
            set_flags_q <= set_flags_d;
            arith_q     <= arith_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            flags_q     <= flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_c     = alu_c_q;
    assign alu_cntrl = alu_cntrl_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign flags     = flags_q;
endmodule
